// File: rtl/plate_char_segment.sv
// Column-histogram character segmenter: latches the plate box, clears and fills a per-column
// white-pixel histogram over one frame, then scans it for spans. Optional CHAR_SEG_GAP_MERGE_EN.
module plate_char_segment #(
    parameter int H_PIXEL   = 1024,
    parameter int V_PIXEL   = 768,
    parameter int MAX_CHARS = 8,
    parameter int COL_TH    = 2,
    parameter int MIN_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_de,
    input  logic [7:0]  gray_b,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    input  logic [10:0] box_x_st,
    input  logic [10:0] box_x_end,
    input  logic [10:0] box_y_st,
    input  logic [10:0] box_y_end,
    input  logic        box_valid,
    output logic        char_valid,
    output logic [3:0]  char_idx,
    output logic [10:0] char_x_st,
    output logic [10:0] char_x_end,
    output logic [3:0]  char_num,
    output logic        seg_done
);
    localparam int AW = $clog2(H_PIXEL);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_SCAN  = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_vsync_d0, w_fs, w_box_ok, w_inv_fs;
    logic [10:0] r_bx_st, r_bx_end, r_by_st, r_by_end;
    logic [AW-1:0] r_clr_addr, r_p1_addr, w_ra, w_wa;
    logic        r_p1_vld, w_hit, w_we;
    logic [9:0]  r_hist [H_PIXEL];
    logic [9:0]  r_rd_data, w_wd;
    logic [10:0] r_scan_x, r_s1_x, r_run_st, r_last_on;
    logic        r_issuing, r_s1_vld, r_s1_last, r_in_run, r_fin_pend;
    logic [3:0]  r_cnt;
    logic        w_eval, w_on, w_close, w_emit, w_eval_fin, w_scan_end;
    logic [10:0] w_run_st, w_run_end, w_width;
    logic        w_char_valid_n, w_seg_done_n;
    logic [3:0]  w_char_idx_n, w_char_num_n;
    logic [10:0] w_char_x_st_n, w_char_x_end_n;
`ifdef CHAR_SEG_GAP_MERGE_EN
    logic [1:0]  r_gap;
`endif

    assign w_fs     = r_vsync_d0 & ~pre_frame_vsync;
    assign w_box_ok = (box_x_end >= box_x_st) && (box_y_end >= box_y_st);
    assign w_inv_fs = (r_state == ST_IDLE) && w_fs && box_valid && !w_box_ok;

    // Frame-start edge detector and FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d0 <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_vsync_d0 <= pre_frame_vsync;
            r_state    <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = (w_fs && box_valid && w_box_ok) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: w_state_nxt = (r_clr_addr == AW'(H_PIXEL - 1)) ? ST_WAIT : ST_CLEAR;
            ST_WAIT:  w_state_nxt = w_fs ? ST_ACCUM : ST_WAIT;
            ST_ACCUM: w_state_nxt = w_fs ? ST_SCAN : ST_ACCUM;
            ST_SCAN:  w_state_nxt = w_scan_end ? ST_IDLE : ST_SCAN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Box latch, clear address and accumulate read stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx_st <= 11'd0; r_bx_end <= 11'd0; r_by_st <= 11'd0; r_by_end <= 11'd0;
            r_clr_addr <= '0;
            r_p1_vld   <= 1'b0;
            r_p1_addr  <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_fs && box_valid && w_box_ok) begin
                r_bx_st <= box_x_st; r_bx_end <= box_x_end;
                r_by_st <= box_y_st; r_by_end <= box_y_end;
            end
            r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + AW'(1) : '0;
            r_p1_vld   <= w_hit;
            r_p1_addr  <= xpos[AW-1:0];
        end
    end

    assign w_hit = (r_state == ST_ACCUM) && pre_frame_de && (gray_b == 8'd255)
                && (xpos >= r_bx_st) && (xpos <= r_bx_end)
                && (ypos >= r_by_st) && (ypos <= r_by_end)
                && ({1'b0, xpos} < 12'(H_PIXEL)) && ({1'b0, ypos} < 12'(V_PIXEL));

    assign w_ra = (r_state == ST_SCAN) ? r_scan_x[AW-1:0] : xpos[AW-1:0];
    assign w_we = (r_state == ST_CLEAR) || r_p1_vld;
    assign w_wa = (r_state == ST_CLEAR) ? r_clr_addr : r_p1_addr;
    assign w_wd = (r_state == ST_CLEAR) ? 10'd0 :
                  (r_rd_data == 10'd1023) ? 10'd1023 : r_rd_data + 10'd1;

    // Histogram RAM; a write to the address being read is forwarded so back-to-back hits chain
    always_ff @(posedge clk) begin
        if (w_we) r_hist[w_wa] <= w_wd;
        if (w_we && (w_wa == w_ra)) r_rd_data <= w_wd;
        else                        r_rd_data <= r_hist[w_ra];
    end

    // Scan read issue: one column per cycle, cut short once the last span slot is used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_x <= 11'd0; r_issuing <= 1'b0; r_s1_vld <= 1'b0;
            r_s1_x   <= 11'd0; r_s1_last <= 1'b0;
        end else if ((r_state == ST_ACCUM) && w_fs) begin
            r_scan_x  <= r_bx_st;
            r_issuing <= 1'b1;
            r_s1_vld  <= 1'b0;
        end else if (w_eval_fin || (r_state != ST_SCAN)) begin
            r_issuing <= 1'b0;
            r_s1_vld  <= 1'b0;
        end else if (r_issuing) begin
            r_s1_vld  <= 1'b1;
            r_s1_x    <= r_scan_x;
            r_s1_last <= (r_scan_x == r_bx_end);
            r_issuing <= (r_scan_x != r_bx_end);
            r_scan_x  <= r_scan_x + 11'd1;
        end else begin
            r_s1_vld  <= 1'b0;
        end
    end

    assign w_eval    = (r_state == ST_SCAN) && r_s1_vld;
    assign w_on      = (r_rd_data >= 10'(COL_TH));
`ifdef CHAR_SEG_GAP_MERGE_EN
    assign w_close   = w_eval && ((r_in_run && !w_on && (r_gap == 2'd2))
                                  || (r_s1_last && (r_in_run || w_on)));
`else
    assign w_close   = w_eval && ((r_in_run && !w_on) || (r_s1_last && (r_in_run || w_on)));
`endif
    assign w_run_st   = r_in_run ? r_run_st : r_s1_x;
    assign w_run_end  = w_on ? r_s1_x : r_last_on;
    assign w_width    = w_run_end - w_run_st + 11'd1;
    assign w_emit     = w_close && (w_width >= 11'(MIN_W));
    assign w_eval_fin = w_eval && (r_s1_last || (w_emit && (r_cnt == 4'(MAX_CHARS - 1))));
    assign w_scan_end = (w_eval_fin && !w_emit) || r_fin_pend;

    // Run tracking and span counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_run <= 1'b0; r_run_st <= 11'd0; r_last_on <= 11'd0;
            r_cnt    <= 4'd0; r_fin_pend <= 1'b0;
`ifdef CHAR_SEG_GAP_MERGE_EN
            r_gap    <= 2'd0;
`endif
        end else begin
            r_fin_pend <= w_eval_fin && w_emit;
            if ((r_state == ST_ACCUM) && w_fs) begin
                r_in_run <= 1'b0;
                r_cnt    <= 4'd0;
`ifdef CHAR_SEG_GAP_MERGE_EN
                r_gap    <= 2'd0;
`endif
            end else if (w_eval) begin
                if (w_emit) r_cnt <= r_cnt + 4'd1;
                if (w_on) begin
                    if (!r_in_run) r_run_st <= r_s1_x;
                    r_in_run  <= 1'b1;
                    r_last_on <= r_s1_x;
`ifdef CHAR_SEG_GAP_MERGE_EN
                    r_gap     <= 2'd0;
                end else if (w_close) begin
                    r_in_run <= 1'b0;
                    r_gap    <= 2'd0;
                end else if (r_in_run) begin
                    r_gap    <= r_gap + 2'd1;
`else
                end else if (w_close) begin
                    r_in_run <= 1'b0;
`endif
                end
            end
        end
    end

    // Output next-value logic
    always_comb begin
        w_char_valid_n = w_emit;
        w_char_idx_n   = char_idx;
        w_char_x_st_n  = char_x_st;
        w_char_x_end_n = char_x_end;
        if (w_emit) begin
            w_char_idx_n   = r_cnt;
            w_char_x_st_n  = w_run_st;
            w_char_x_end_n = w_run_end;
        end else begin
            w_char_idx_n   = char_idx;
        end
        w_seg_done_n = w_inv_fs || w_scan_end;
        if (w_inv_fs)        w_char_num_n = 4'd0;
        else if (w_scan_end) w_char_num_n = r_cnt;
        else                 w_char_num_n = char_num;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_valid <= 1'b0; char_idx <= 4'd0; char_x_st <= 11'd0;
            char_x_end <= 11'd0; char_num <= 4'd0; seg_done <= 1'b0;
        end else begin
            char_valid <= w_char_valid_n; char_idx <= w_char_idx_n;
            char_x_st  <= w_char_x_st_n;  char_x_end <= w_char_x_end_n;
            char_num   <= w_char_num_n;   seg_done <= w_seg_done_n;
        end
    end
endmodule

// File: doc/plate_char_segment.md
# plate_char_segment

Character segmentation stage fed by the plate-localization block. It latches the plate bounding box and the localization-done flag, then clears a per-column histogram RAM. Over one full frame it accumulates white-pixel counts per column inside the box, then scans the histogram and reports up to MAX_CHARS character column spans.

## Interface
- H_PIXEL, 1024: columns per frame; histogram RAM depth.
- V_PIXEL, 768: rows per frame.
- MAX_CHARS, 8: maximum spans reported per frame (≤ 15).
- COL_TH, 2: minimum white count for a column to be a character column.
- MIN_W, 4: minimum run width in columns for a run to be reported.

- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pre_frame_vsync  in  1  frame sync; the falling edge marks frame start.
- pre_frame_de  in  1  pixel valid.
- gray_b  in  8  binarized pixel; the value 8'd255 means white.
- xpos  in  11  pixel column.
- ypos  in  11  pixel row.
- box_x_st, box_x_end, box_y_st, box_y_end  in  11 each  plate box, inclusive bounds.
- box_valid  in  1  box is valid; this is the localization-done flag.
- char_valid  out  1  one-cycle pulse; a span is being presented.
- char_idx  out  4  index of the span, from 0 to MAX_CHARS-1.
- char_x_st, char_x_end  out  11 each  span bounds, inclusive.
- char_num  out  4  number of spans found; updated at seg_done.
- seg_done  out  1  one-cycle pulse; the scan is complete.

## Operation
- The frame-start strobe (fs) is `vsync_d0 & ~pre_frame_vsync`, where vsync_d0 is registered.
- The state machine has five states: IDLE, CLEAR, WAIT, ACCUM, SCAN.
  - IDLE: when fs and box_valid are both 1, latch the four box bounds and go to CLEAR.
    - The latched box is used for the whole frame; later changes to the box inputs or box_valid are ignored.
  - CLEAR: write 0 to addresses 0..H_PIXEL-1, one address per cycle, then go to WAIT.
  - WAIT: on the next fs, go to ACCUM.
  - ACCUM: count a pixel when pre_frame_de=1, gray_b==255, box_x_st≤xpos≤box_x_end and box_y_st≤ypos≤box_y_end.
    - Each counted pixel does a read-modify-write of hist[xpos] through a 2-stage pipeline: read address, then write count+1.
    - When the write address equals the address read in the same cycle, forward the new value.
    - Counters are 10 bits and saturate at 1023.
    - On the next fs, go to SCAN.
  - SCAN: read columns box_x_st..box_x_end in order, one per cycle.
    - A column is "on" when count ≥ COL_TH.
    - The run start is the first on column; the run end is the last on column before an off column, or box_x_end.
    - A run of width (end-st+1) ≥ MIN_W emits one char_valid pulse carrying char_idx, char_x_st and char_x_end, then char_idx increments.
    - Runs with width < MIN_W are discarded silently.
    - After MAX_CHARS spans are emitted, stop emitting and finish the scan early.
    - At the end of the scan, register char_num, pulse seg_done and go to IDLE.
- Invalid box (box_x_end < box_x_st or box_y_end < box_y_st) in IDLE:
  - Skip CLEAR, WAIT, ACCUM and SCAN.
  - Pulse seg_done with char_num=0 on the cycle after the fs, then remain in IDLE.
- fs arriving during CLEAR: ignored; WAIT waits for the following fs.
- Reset: all outputs 0, state IDLE, latched box 0. Asserting reset mid-frame abandons the operation. Histogram contents are not reset (CLEAR handles that).

## Timing
- Latency from IDLE fs to the first ACCUM cycle: H_PIXEL+1 cycles of clear, plus the wait for the next fs.
- ACCUM throughput: 1 pixel/cycle with no stall; the histogram is final 2 cycles after the last valid pixel.
- SCAN issues one read per cycle, with 1-cycle RAM read latency.
- char_valid is asserted 2 cycles after the read of the column that closes the run. For a run closed by box_x_end, it is 2 cycles after reading box_x_end.
- seg_done is asserted the cycle after the last char_valid slot, or 2 cycles after the final read if no span closes there. It is never in the same cycle as char_valid.
- char_x_st, char_x_end and char_idx hold their last values between pulses; char_num holds until the next seg_done.
- A full-width scan takes W+3 cycles, where W = box_x_end-box_x_st+1.

## Configuration
- CHAR_SEG_GAP_MERGE_EN:
  - When defined, an off-gap of ≤2 columns between two on runs does not close the run; the runs merge into one span, for split-stroke glyphs.
    - Run closure, and so char_valid, is delayed until 3 consecutive off columns are seen or box_x_end is reached.
    - char_x_end is still the last on column.
  - When undefined, any single off column closes the run.

## Test plan
- Reset: all outputs 0; stays in IDLE with box_valid=0 across 3 frames; no seg_done.
- Box (100..199, 50..89), white columns 110–119 and 130–131 at every row, 1 column elsewhere → char_valid once: idx 0, x 110..119. Run 130–131 (width 2 < MIN_W) dropped; char_num=1.
- Same box, ten white runs of width 5 separated by 3 columns → exactly 8 char_valid pulses (idx 0..7); scan ends early; char_num=8.
- White run reaching box_x_end=199 (cols 190..199) → final span 190..199 closed by the box edge.
- Runs 140–144 and 146–150 with a 1-column gap → MERGE_EN: one span 140..150; without: two spans.
- Invalid box (x_end=10 < x_st=20) → seg_done one cycle after fs, char_num=0, no char_valid.
